// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry constants, fill FSM state type and block-base helper
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int BLOCK_WORDS_DEFAULT = 8;
  localparam int OFFSET_W_DEFAULT    = 3;
  localparam int BYTE_OFFSET_W       = 1;
  localparam int ADDR_W              = 16;
  localparam int DATA_W              = 16;

  // Clears the word-offset and byte-offset bits, leaving the block-aligned byte address.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr,
                                                   input int offset_w);
    logic [ADDR_W-1:0] mask;
    mask = (ADDR_W'(1) << (offset_w + BYTE_OFFSET_W)) - ADDR_W'(1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - up-counter with async reset, synchronous clear and count enable
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss fill controller: issues block word reads and steers returning words into the data array
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
  parameter int OFFSET_W    = $clog2(BLOCK_WORDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_detected,
  input  logic [ADDR_W-1:0]   miss_address,
  output logic                fsm_busy,
  output logic                memory_read,
  output logic [ADDR_W-1:0]   memory_address,
  input  logic                memory_data_valid,
  input  logic [DATA_W-1:0]   memory_data,
  output logic                write_data_array,
  output logic                write_tag_array,
  output logic [OFFSET_W-1:0] cache_word_offset,
  output logic [DATA_W-1:0]   cache_write_data
);

  localparam int CNT_W = OFFSET_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

  fill_state_t       state;
  fill_state_t       state_next;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic              start;
  logic              issue;
  logic              accept;

  assign start  = (state == IDLE) && miss_detected;
  assign issue  = (state == FILL) && (req_cnt < CNT_FULL);
  assign accept = (state == FILL) && memory_data_valid;

  fill_counter #(.W(CNT_W)) u_req_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start),
    .enable (issue),
    .count  (req_cnt)
  );

  fill_counter #(.W(CNT_W)) u_rcv_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start),
    .enable (accept),
    .count  (rcv_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        base <= block_base(miss_address, OFFSET_W);
      end
    end
  end

  // The stall is raised combinationally in IDLE so the pipeline freezes in the miss cycle itself.
  always_comb begin
    state_next        = state;
    fsm_busy          = 1'b0;
    memory_read       = 1'b0;
    memory_address    = '0;
    write_data_array  = 1'b0;
    write_tag_array   = 1'b0;
    cache_word_offset = '0;
    case (state)
      IDLE: begin
        fsm_busy = miss_detected;
        if (miss_detected) begin
          state_next = FILL;
        end
      end
      FILL: begin
        fsm_busy    = 1'b1;
        memory_read = issue;
        if (issue) begin
          memory_address = base + (ADDR_W'(req_cnt) << 1);
        end
        if (memory_data_valid) begin
          write_data_array  = 1'b1;
          cache_word_offset = rcv_cnt[OFFSET_W-1:0];
          // Completion is keyed on returned words only, independent of request progress.
          if (rcv_cnt == CNT_LAST) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cache_write_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm with latency memory model and scoreboard
module tb_cache_fill_fsm;

  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  cache_word_offset;
  logic [15:0] cache_write_data;

  cache_fill_fsm #(.BLOCK_WORDS(BW), .OFFSET_W(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .cache_word_offset (cache_word_offset),
    .cache_write_data  (cache_write_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [15:0] data; } mem_t;
  typedef struct { int cyc; logic [15:0] addr; } rd_t;
  typedef struct { int cyc; logic [2:0] off; logic [15:0] data; logic tag; } wr_t;

  mem_t pend[$];
  rd_t  exp_rd[$];
  wr_t  exp_wr[$];
  rd_t  rd_e;
  wr_t  wr_e;

  int checks = 0;
  int failures = 0;
  int lat = 4;
  int t0;

  logic        mem_v = 1'b0;
  logic        inj_v = 1'b0;
  logic [15:0] mem_d = '0;
  logic [15:0] inj_d = '0;

  assign memory_data_valid = mem_v | inj_v;
  assign memory_data       = mem_v ? mem_d : inj_d;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Main memory: answers each sampled request exactly lat cycles later, in order.
  always @(posedge clk) begin
    #1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_v <= 1'b1;
      mem_d <= pend[0].data;
      void'(pend.pop_front());
    end else begin
      mem_v <= 1'b0;
      mem_d <= 16'($urandom);
    end
  end

  // Scoreboard: every request and every array write must match the next expected entry.
  always @(negedge clk) begin
    if (memory_read) begin
      pend.push_back('{cyc + lat, pat(memory_address)});
      checks++;
      if (exp_rd.size() == 0) begin
        failures++;
        $display("FAIL read_unexpected cyc=%0d addr=%h required no read", cyc, memory_address);
      end else begin
        rd_e = exp_rd.pop_front();
        if (rd_e.cyc !== cyc || rd_e.addr !== memory_address) begin
          failures++;
          $display("FAIL read cyc=%0d addr=%h required cyc=%0d addr=%h",
                   cyc, memory_address, rd_e.cyc, rd_e.addr);
        end
      end
    end
    if (write_data_array) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected cyc=%0d off=%0d required no write", cyc, cache_word_offset);
      end else begin
        wr_e = exp_wr.pop_front();
        if (wr_e.cyc !== cyc || wr_e.off !== cache_word_offset ||
            wr_e.data !== cache_write_data || wr_e.tag !== write_tag_array) begin
          failures++;
          $display("FAIL write cyc=%0d off=%0d data=%h tag=%b required cyc=%0d off=%0d data=%h tag=%b",
                   cyc, cache_word_offset, cache_write_data, write_tag_array,
                   wr_e.cyc, wr_e.off, wr_e.data, wr_e.tag);
        end
      end
    end else if (write_tag_array) begin
      checks++;
      failures++;
      $display("FAIL tag_without_data cyc=%0d tag=1 required 0", cyc);
    end
  end

  task automatic expect_fill(input logic [15:0] base, input int t, input int l,
                             input int n_rd, input int n_wr);
    for (int i = 0; i < n_rd; i++) exp_rd.push_back('{t + 1 + i, base + 16'(2 * i)});
    for (int i = 0; i < n_wr; i++)
      exp_wr.push_back('{t + 1 + l + i, 3'(i), pat(base + 16'(2 * i)), (i == BW - 1)});
  endtask

  task automatic begin_miss(input logic [15:0] addr, input logic [15:0] base, input int l);
    @(posedge clk);
    #1;
    lat = l;
    t0 = cyc;
    expect_fill(base, t0, l, BW, BW);
    miss_detected = 1'b1;
    miss_address  = addr;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({fsm_busy, memory_read, write_data_array, write_tag_array} !== 4'b0 ||
        memory_address !== 16'h0 || cache_word_offset !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b rd=%b wda=%b wta=%b addr=%h off=%0d required all 0",
               fsm_busy, memory_read, write_data_array, write_tag_array, memory_address, cache_word_offset);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic_fill();
    begin_miss(16'h1236, 16'h1230, 4);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      checks++;
      if (fsm_busy !== (k <= 12)) begin
        failures++;
        $display("FAIL basic_busy k=%0d busy=%b required %b", k, fsm_busy, (k <= 12));
      end
      @(posedge clk);
      #1;
      if (k == 0) miss_detected = 1'b0;
    end
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      failures++;
      $display("FAIL basic_drain rd_left=%0d wr_left=%0d required 0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_overlap();
    begin_miss(16'h0A10, 16'h0A10, 1);
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (fsm_busy !== (k <= 9)) begin
        failures++;
        $display("FAIL overlap_busy k=%0d busy=%b required %b", k, fsm_busy, (k <= 9));
      end
      @(posedge clk);
      #1;
      if (k == 0) miss_detected = 1'b0;
    end
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      failures++;
      $display("FAIL overlap_drain rd_left=%0d wr_left=%0d required 0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_top_of_memory();
    begin_miss(16'hFFFF, 16'hFFF0, 2);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (fsm_busy !== (k <= 10)) begin
        failures++;
        $display("FAIL top_busy k=%0d busy=%b required %b", k, fsm_busy, (k <= 10));
      end
      @(posedge clk);
      #1;
      if (k == 0) miss_detected = 1'b0;
    end
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      failures++;
      $display("FAIL top_drain rd_left=%0d wr_left=%0d required 0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_spurious();
    @(posedge clk);
    #1;
    inj_v = 1'b1;
    inj_d = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (write_data_array !== 1'b0 || fsm_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_valid wda=%b busy=%b required 0 0", write_data_array, fsm_busy);
    end
    @(posedge clk);
    #1;
    inj_v = 1'b0;
    begin_miss(16'h0456, 16'h0450, 3);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if (fsm_busy !== (k <= 11)) begin
        failures++;
        $display("FAIL spurious_busy k=%0d busy=%b required %b", k, fsm_busy, (k <= 11));
      end
      @(posedge clk);
      #1;
      miss_detected = (k == 0) ? 1'b0 : (k == 2);
      if (k == 2) miss_address = 16'h9990;
    end
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      failures++;
      $display("FAIL spurious_drain rd_left=%0d wr_left=%0d required 0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    @(posedge clk);
    #1;
    lat = 4;
    t0 = cyc;
    expect_fill(16'h2000, t0, 4, 5, 1);
    miss_detected = 1'b1;
    miss_address  = 16'h2000;
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      checks++;
      if (fsm_busy !== (k <= 5 || (k >= 14 && k <= 26))) begin
        failures++;
        $display("FAIL rst_busy k=%0d busy=%b required %b", k, fsm_busy, (k <= 5 || (k >= 14 && k <= 26)));
      end
      if (k == 6) begin
        checks++;
        if ({memory_read, write_data_array, write_tag_array} !== 3'b0 ||
            memory_address !== 16'h0 || cache_word_offset !== 3'd0) begin
          failures++;
          $display("FAIL rst_outputs rd=%b wda=%b wta=%b addr=%h off=%0d required all 0",
                   memory_read, write_data_array, write_tag_array, memory_address, cache_word_offset);
        end
      end
      @(posedge clk);
      #1;
      if (k + 1 == 6) rst_n = 1'b0;
      if (k + 1 == 8) rst_n = 1'b1;
      inj_v = (k + 1 >= 7 && k + 1 <= 12);
      inj_d = 16'h5A00 + 16'(k);
      miss_detected = (k + 1 == 14);
      if (k + 1 == 14) begin
        miss_address = 16'h3000;
        expect_fill(16'h3000, t0 + 14, 4, BW, BW);
      end
    end
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      failures++;
      $display("FAIL rst_drain rd_left=%0d wr_left=%0d required 0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_back_to_back();
    begin_miss(16'h0040, 16'h0040, 4);
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      checks++;
      if (fsm_busy !== (k <= 25)) begin
        failures++;
        $display("FAIL b2b_busy k=%0d busy=%b required %b", k, fsm_busy, (k <= 25));
      end
      @(posedge clk);
      #1;
      miss_detected = (k + 1 == 13);
      if (k + 1 == 13) begin
        miss_address = 16'h0080;
        expect_fill(16'h0080, t0 + 13, 4, BW, BW);
      end
    end
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain rd_left=%0d wr_left=%0d required 0", exp_rd.size(), exp_wr.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_fill();
    test_overlap();
    test_top_of_memory();
    test_spurious();
    test_reset_mid_fill();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
